// File: rtl/joy_db15_tx_if.sv
// Host-facing signal bundle of the DB15 shift-chain emulator.
// The master side is the host/stimulus; the slave side is the emulated adapter.
interface joy_db15_tx_if;
  logic        joy_clk_in;
  logic        joy_load_in;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        joy_data_out;
  logic        frame_done;
  logic [5:0]  bit_cnt;
  logic        host_active;

  modport master (
    output joy_clk_in, joy_load_in, joystick1, joystick2,
    input  joy_data_out, frame_done, bit_cnt, host_active
  );

  modport slave (
    input  joy_clk_in, joy_load_in, joystick1, joystick2,
    output joy_data_out, frame_done, bit_cnt, host_active
  );
endinterface

// File: rtl/joy_db15_tx.sv
// Device-side model of the DB15 adapter's parallel-in/serial-out chain:
// answers host JOY_LOAD/JOY_CLK strobes with active-low serial button data.
module joy_db15_tx #(
  parameter int          PLAYERS     = 2,
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] TIMEOUT     = 24'd4800000
) (
  input logic          clk,
  input logic          RESET_N,
  joy_db15_tx_if.slave joy
);

  localparam int         FRAME_BITS = 16 * PLAYERS;
  localparam logic [5:0] FRAME_CNT  = 6'(FRAME_BITS);
  localparam logic [5:0] LAST_CNT   = 6'(FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] load_sync_r;
  logic                   clk_prev_r;
  logic                   load_prev_r;
  logic [FRAME_BITS-1:0]  sr_r;
  logic                   data_r;
  logic                   frame_done_r;
  logic [5:0]             bit_cnt_r;
  logic                   host_active_r;
  logic [23:0]            wd_r;

  logic                   clk_rise_s;
  logic                   load_low_s;
  logic                   load_fall_s;
  logic [31:0]            word_full_s;
  logic [FRAME_BITS-1:0]  load_word_s;

  assign clk_rise_s  = clk_sync_r[SYNC_STAGES-1] & ~clk_prev_r;
  assign load_low_s  = ~load_sync_r[SYNC_STAGES-1];
  assign load_fall_s = load_low_s & load_prev_r;
  // Player 1 sits in the low half so joystick1[0] is the first bit out.
  assign word_full_s = ~{joy.joystick2, joy.joystick1};
  assign load_word_s = word_full_s[FRAME_BITS-1:0];

  // Synchronize host strobes and keep one extra copy for edge detection.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync_r  <= '1;
      load_sync_r <= '1;
      clk_prev_r  <= 1'b1;
      load_prev_r <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], joy.joy_clk_in};
      load_sync_r <= {load_sync_r[SYNC_STAGES-2:0], joy.joy_load_in};
      clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
      load_prev_r <= load_sync_r[SYNC_STAGES-1];
    end
  end

  // Shift chain: level-sensitive load wins over a coincident shift edge.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sr_r         <= '1;
      data_r       <= 1'b1;
      bit_cnt_r    <= 6'd0;
      frame_done_r <= 1'b0;
    end else begin
      data_r <= sr_r[0];
      if (load_low_s) begin
        sr_r         <= load_word_s;
        bit_cnt_r    <= 6'd0;
        frame_done_r <= 1'b0;
      end else if (clk_rise_s) begin
        sr_r         <= {1'b1, sr_r[FRAME_BITS-1:1]};
        frame_done_r <= (bit_cnt_r == LAST_CNT);
        if (bit_cnt_r != FRAME_CNT) begin
          bit_cnt_r <= bit_cnt_r + 6'd1;
        end else begin
          bit_cnt_r <= bit_cnt_r;
        end
      end else begin
        frame_done_r <= 1'b0;
      end
    end
  end

  // Host watchdog: host_active drops once TIMEOUT clks pass without a load strobe.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      wd_r          <= 24'd0;
      host_active_r <= 1'b0;
    end else begin
      if (load_fall_s) begin
        wd_r          <= 24'd0;
        host_active_r <= 1'b1;
      end else if (wd_r != TIMEOUT) begin
        wd_r <= wd_r + 24'd1;
        if (wd_r == TIMEOUT - 24'd1) begin
          host_active_r <= 1'b0;
        end else begin
          host_active_r <= host_active_r;
        end
      end else begin
        host_active_r <= 1'b0;
      end
    end
  end

  assign joy.joy_data_out = data_r;
  assign joy.frame_done   = frame_done_r;
  assign joy.bit_cnt      = bit_cnt_r;
  assign joy.host_active  = host_active_r;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: a two-player and a one-player instance share
// host stimulus; expected serial bits are queued at load time and popped per shift.
`timescale 1ns/1ps
module tb_joy_db15_tx;

  logic        clk;
  logic        rst_n;
  logic        joy_clk;
  logic        joy_load;
  logic [15:0] j1;
  logic [15:0] j2;

  int n_checks = 0;
  int n_errors = 0;
  int fd_a_total = 0;
  int fd_b_total = 0;

  logic qa[$];
  logic qb[$];

  joy_db15_tx_if if_a ();
  joy_db15_tx_if if_b ();

  assign if_a.joy_clk_in  = joy_clk;
  assign if_a.joy_load_in = joy_load;
  assign if_a.joystick1   = j1;
  assign if_a.joystick2   = j2;
  assign if_b.joy_clk_in  = joy_clk;
  assign if_b.joy_load_in = joy_load;
  assign if_b.joystick1   = j1;
  assign if_b.joystick2   = j2;

  joy_db15_tx #(.PLAYERS(2), .SYNC_STAGES(2), .TIMEOUT(24'd100)) dut_a (
    .clk(clk), .RESET_N(rst_n), .joy(if_a.slave)
  );

  joy_db15_tx #(.PLAYERS(1), .SYNC_STAGES(2), .TIMEOUT(24'd100)) dut_b (
    .clk(clk), .RESET_N(rst_n), .joy(if_b.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (if_a.frame_done === 1'b1) fd_a_total = fd_a_total + 1;
    if (if_b.frame_done === 1'b1) fd_b_total = fd_b_total + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish within 2 ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_errors = n_errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int bits, input logic to_b);
    logic [31:0] w;
    w = ~{j2, j1};
    for (int i = 0; i < bits; i++) begin
      if (to_b) qb.push_back(w[i]);
      else      qa.push_back(w[i]);
    end
  endtask

  task automatic push_ones(input int n);
    for (int i = 0; i < n; i++) qa.push_back(1'b1);
  endtask

  task automatic load_pulse();
    @(negedge clk);
    joy_load = 1'b0;
    repeat (8) @(negedge clk);
    joy_load = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // One host shift cycle: compare the presented bit, then rising and falling edge.
  task automatic joy_clk_cycle();
    logic e;
    @(negedge clk);
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check("data_a", {31'd0, if_a.joy_data_out}, {31'd0, e});
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check("data_b", {31'd0, if_b.joy_data_out}, {31'd0, e});
    end
    joy_clk = 1'b1;
    repeat (25) @(negedge clk);
    joy_clk = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  initial begin
    int base_a;
    int base_b;
    int wait_n;
    int high_n;

    rst_n    = 1'b0;
    joy_clk  = 1'b0;
    joy_load = 1'b1;
    j1       = 16'h0000;
    j2       = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_data_a", {31'd0, if_a.joy_data_out}, 32'd1);
    check("rst_cnt_a", {26'd0, if_a.bit_cnt}, 32'd0);
    check("rst_fd_a", {31'd0, if_a.frame_done}, 32'd0);
    check("rst_ha_a", {31'd0, if_a.host_active}, 32'd0);
    check("rst_data_b", {31'd0, if_b.joy_data_out}, 32'd1);
    check("rst_ha_b", {31'd0, if_b.host_active}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: shifting without any load yields ones only
    push_ones(40);
    for (int i = 0; i < 40; i++) joy_clk_cycle();
    check("noload_cnt_sat", {26'd0, if_a.bit_cnt}, 32'd32);
    check("noload_ha", {31'd0, if_a.host_active}, 32'd0);

    // 2: two-player frame with distinct patterns
    j1 = 16'h0005;
    j2 = 16'h8000;
    load_pulse();
    check("load_ha", {31'd0, if_a.host_active}, 32'd1);
    check("load_cnt", {26'd0, if_a.bit_cnt}, 32'd0);
    base_a = fd_a_total;
    push_frame(32, 1'b0);
    for (int i = 0; i < 31; i++) joy_clk_cycle();
    check("fd_before_last", fd_a_total - base_a, 32'd0);
    joy_clk_cycle();
    check("fd_once", fd_a_total - base_a, 32'd1);
    check("cnt_full", {26'd0, if_a.bit_cnt}, 32'd32);
    check("after_frame_data", {31'd0, if_a.joy_data_out}, 32'd1);

    // 3: over-clocking reads ones, no extra frame_done
    push_ones(8);
    for (int i = 0; i < 8; i++) joy_clk_cycle();
    check("over_cnt", {26'd0, if_a.bit_cnt}, 32'd32);
    check("over_fd", fd_a_total - base_a, 32'd1);

    // 4: reload mid-frame, with a coincident shift edge that must be dropped
    load_pulse();
    push_frame(32, 1'b0);
    for (int i = 0; i < 10; i++) joy_clk_cycle();
    qa.delete();
    check("pre_reload_cnt", {26'd0, if_a.bit_cnt}, 32'd10);
    @(negedge clk);
    j1       = 16'h0001;
    joy_load = 1'b0;
    joy_clk  = 1'b1;
    repeat (4) @(negedge clk);
    check("reload_data_lat4", {31'd0, if_a.joy_data_out}, 32'd0);
    check("reload_cnt", {26'd0, if_a.bit_cnt}, 32'd0);
    repeat (6) @(negedge clk);
    check("coincident_edge_cnt", {26'd0, if_a.bit_cnt}, 32'd0);
    joy_clk = 1'b0;
    repeat (4) @(negedge clk);
    joy_load = 1'b1;
    repeat (8) @(negedge clk);
    push_frame(32, 1'b0);
    for (int i = 0; i < 5; i++) joy_clk_cycle();
    j1 = 16'hFFFF;
    for (int i = 0; i < 27; i++) joy_clk_cycle();
    check("reload_frame_cnt", {26'd0, if_a.bit_cnt}, 32'd32);

    // 5: watchdog with TIMEOUT=100
    check("wd_idle_low", {31'd0, if_a.host_active}, 32'd0);
    @(negedge clk);
    joy_load = 1'b0;
    wait_n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (if_a.host_active === 1'b1 && wait_n == 0) wait_n = i;
    end
    joy_load = 1'b1;
    check("wd_rise_lat", wait_n, 32'd3);
    high_n = 10 - wait_n + 1;
    for (int i = 0; i < 300; i++) begin
      if (if_a.host_active !== 1'b1) break;
      @(negedge clk);
      if (if_a.host_active === 1'b1) high_n = high_n + 1;
    end
    check("wd_high_cycles", high_n, 32'd100);
    check("wd_low_after", {31'd0, if_a.host_active}, 32'd0);

    // 6: asynchronous reset mid-frame, then one-player frame
    j1 = 16'h0005;
    load_pulse();
    push_frame(32, 1'b0);
    for (int i = 0; i < 12; i++) joy_clk_cycle();
    qa.delete();
    check("pre_reset_cnt", {26'd0, if_a.bit_cnt}, 32'd12);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #0.5;
    check("async_rst_data", {31'd0, if_a.joy_data_out}, 32'd1);
    check("async_rst_cnt", {26'd0, if_a.bit_cnt}, 32'd0);
    check("async_rst_ha", {31'd0, if_a.host_active}, 32'd0);
    check("async_rst_fd", {31'd0, if_a.frame_done}, 32'd0);
    #0.5;
    rst_n = 1'b1;
    push_ones(3);
    for (int i = 0; i < 3; i++) joy_clk_cycle();
    check("post_rst_cnt", {26'd0, if_a.bit_cnt}, 32'd3);

    j1 = 16'h8001;
    j2 = 16'h1234;
    load_pulse();
    push_frame(16, 1'b1);
    base_b = fd_b_total;
    for (int i = 0; i < 15; i++) joy_clk_cycle();
    check("p1_fd_before", fd_b_total - base_b, 32'd0);
    joy_clk_cycle();
    check("p1_fd_once", fd_b_total - base_b, 32'd1);
    check("p1_cnt", {26'd0, if_b.bit_cnt}, 32'd16);
    check("p1_tail_data", {31'd0, if_b.joy_data_out}, 32'd1);
    check("scoreboard_empty_b", qb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
Device-side emulator of the DB15 joystick adapter's parallel-in/serial-out shift chain. It responds to the host's JOY_CLK/JOY_LOAD strobes with JOY_DATA, exactly as the adapter's shift-register chain would. It pairs with the existing DB15 receiver: either as a loopback/verification model, or to drive a second MiSTer's UserIO port from our own joystick state. It sits on the joystick clock domain (40–50 MHz) next to the DB9MD/DB15 receivers.

Parameters:
PLAYERS, 2, number of 16-bit player words in a frame (1 or 2)
SYNC_STAGES, 2, synchronizer flops on joy_clk_in/joy_load_in (min 2)
TIMEOUT, 24'd4800000, clk cycles without a load strobe before host_active drops (~100 ms at 48 MHz)

Ports:
clk  in  1  joystick clock, 40–50 MHz
RESET_N  in  1  asynchronous active-low reset
joy_clk_in  in  1  host shift clock, asynchronous to clk
joy_load_in  in  1  host parallel-load strobe, active low, asynchronous
joystick1  in  16  player 1 state, active high, receiver bit layout (LS FEDCBA UDLR)
joystick2  in  16  player 2 state, active high; ignored when PLAYERS=1
joy_data_out  out  1  serial data to host, active low (0 = pressed)
frame_done  out  1  one-clk pulse when the last frame bit has been shifted past
bit_cnt  out  6  number of shifts since last load, saturating at FRAME_BITS
host_active  out  1  high while host strobes load at least once per TIMEOUT

Behaviour:
- FRAME_BITS = 16*PLAYERS. Internal shift register sr[FRAME_BITS-1:0]. joy_data_out is registered and equals sr[0].
- Reset (async, RESET_N=0) sets: sr all ones, joy_data_out=1, frame_done=0, bit_cnt=0, host_active=0, watchdog counter 0, synchronizer flops 1.
- Input conditioning: joy_clk_in and joy_load_in each pass through SYNC_STAGES flops. Edge detection compares the last sync stage with one further registered copy.
- Load, level-sensitive: while synced load=0, every clk sr <= ~{joystick2,joystick1} (PLAYERS=2) or ~joystick1 (PLAYERS=1), and bit_cnt <= 0. Inputs keep being re-sampled for the whole load-low period.
- Frame bit order: the first bit presented is joystick1[0], then joystick1[15:1], then joystick2[0..15].
- Shift: on a synced rising edge of joy_clk with synced load=1, sr <= {1'b1, sr[FRAME_BITS-1:1]}. Ones fill in, so over-clocking reads "no button".
  - bit_cnt increments, saturating at FRAME_BITS.
- frame_done pulses for one clk on the shift that moves bit_cnt from FRAME_BITS-1 to FRAME_BITS. Further shifts produce no pulse.
- Priority: load low beats a simultaneous clk rising edge; that edge is discarded.
- Latency: a pin edge on joy_clk_in or joy_load_in affects joy_data_out SYNC_STAGES+2 clk later. With the default this is 4 clk, which must stay under half the host's JOY_CLK period.
- Falling edges of joy_clk have no effect.
- Watchdog:
  - Every synced falling edge of load clears the counter and sets host_active=1.
  - Otherwise the counter increments, saturating at TIMEOUT.
  - When it reaches TIMEOUT, host_active <= 0.
  - Shifting is not gated by host_active.
- Reset mid-frame: state returns to reset values immediately. The first valid frame requires a new load strobe; until then, edges on joy_clk shift out ones.
- joystick inputs are sampled only during load. Changes while shifting do not affect the frame in flight.

Test Plan:
1. Reset -> joy_data_out=1, bit_cnt=0, frame_done=0, host_active=0; 40 joy_clk pulses with no load produce all ones.
2. joystick1=16'h0005, joystick2=16'h8000, load pulse, then 32 joy_clk rising edges (period 1 µs) -> serial stream 0,1,0 then ones through bit 30, then bit 31=0. frame_done pulses once after the 32nd edge; bit_cnt=32.
3. 8 further edges after scenario 2 -> joy_data_out stays 1, bit_cnt stays 32, no frame_done.
4. Load asserted after 10 shifts with joystick1=16'h0001 -> bit_cnt=0, joy_data_out=0 within 4 clk; a joy_clk edge coincident with load low is ignored (bit_cnt stays 0).
5. Load strobe, then none for TIMEOUT cycles (TIMEOUT overridden to 100) -> host_active goes 1 after strobe and returns to 0 exactly 100 clk after the falling-edge detection.
6. RESET_N pulsed low for 1 ns mid-frame (bit_cnt=12) -> all outputs to reset values asynchronously; PLAYERS=1 build: frame_done after the 16th edge.
